checkerboard_patgen: RTL and testbench
======================================

CHECKERBOARD_PATGEN -- requirements
Module: checkerboard_patgen

Interface
REQ-001 Parameter MAX_ADDR, default 255, highest SRAM address exercised; the address range is 0..MAX_ADDR.
REQ-002 Parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 Parameter MASK_WIDTH, default 4, write-mask width.
REQ-004 Parameter ADDR_WIDTH, default $clog2(MAX_ADDR+1), address width.
REQ-005 clk  input  1  sole clock; all state updates on its posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  advance enable; the block SHALL issue and advance one operation per cycle only while en=1.
REQ-008 done  output  1  high once all phases have completed.
REQ-009 addr  output  ADDR_WIDTH  SRAM address of the current operation.
REQ-010 data  output  DATA_WIDTH  write data.
REQ-011 wmask  output  MASK_WIDTH  write mask.
REQ-012 we  output  1  write strobe.
REQ-013 re  output  1  read strobe.
REQ-014 expected  output  DATA_WIDTH  read data the checker compares one cycle after re.

Function
REQ-015 Background pattern bg(a) SHALL have bit i = i[0] XOR a[0]:
  - even address: 8-bit value 0xAA.
  - odd address: 8-bit value 0x55.
REQ-016 Phases SHALL run in order W_CB, R_CB, W_ICB, R_ICB, DONE:
  - W_CB: write bg.
  - R_CB: read, expecting bg.
  - W_ICB: write ~bg.
  - R_ICB: read, expecting ~bg.
REQ-017 Each active phase SHALL sweep addr from 0 to MAX_ADDR, ascending by 1 per enabled cycle.
REQ-018 On an enabled cycle at addr==MAX_ADDR, the block SHALL wrap addr to 0 and advance to the next phase.
REQ-019 All outputs SHALL be combinational functions of the registered phase/addr and en; the operation is presented in the same cycle as its state.
REQ-020 In write phases:
  - we=en, re=0.
  - data = pattern for the phase.
  - wmask = all ones.
  - expected = 0.
REQ-021 In read phases:
  - re=en, we=0.
  - expected = pattern for the phase.
  - data = 0, wmask = 0.
REQ-022 With en=0, we and re SHALL be 0, and phase and addr SHALL hold.
REQ-023 In DONE:
  - done=1; we=re=0; addr, data, wmask and expected = 0.
  - The block SHALL stay in DONE regardless of en until rst.
REQ-024 Outside DONE, done SHALL be 0.
REQ-025 With MAX_ADDR=0, each phase SHALL last exactly one enabled cycle.
REQ-026 Without the configuration macro, the total is 4*(MAX_ADDR+1) enabled cycles from reset to done=1.

Reset
REQ-027 rst=1 SHALL set phase=W_CB and addr=0 on the next posedge, overriding en.
REQ-028 rst=1 SHALL abort any phase in progress, including DONE.
REQ-029 After reset, done=0; we=en; addr=0; data=bg(0); wmask all ones.

Configuration
REQ-030 When CHECKERBOARD_DESC_READ_EN is defined:
  - A descending read phase (MAX_ADDR down to 0) SHALL be inserted after R_CB, expecting bg.
  - A descending read phase SHALL be inserted after R_ICB, expecting ~bg.
  - The total becomes 6*(MAX_ADDR+1) enabled cycles.
REQ-031 When CHECKERBOARD_DESC_READ_EN is undefined, only the four ascending phases SHALL exist and no descending logic SHALL be present.

Verification
REQ-032 MAX_ADDR=3, DATA_WIDTH=8, en=1 after reset:
  - Cycles 0-3: we=1, addr 0,1,2,3, data AA,55,AA,55.
  - Cycles 4-7: re=1, expected AA,55,AA,55.
  - Cycles 8-11: we=1, data 55,AA,55,AA.
  - Cycles 12-15: re=1, expected 55,AA,55,AA.
  - Cycle 16: done=1.
REQ-033 Same configuration, en=0 at cycles 5-7, then en=1:
  - we=re=0 and addr=1 held during the stall.
  - Reads resume at addr=1; done=1 at cycle 19.
REQ-034 rst=1 at cycle 10, during W_ICB at addr=2:
  - Next cycle: addr=0, we=1, data=AA.
  - done=1 exactly 16 enabled cycles after reset is released.
REQ-035 MAX_ADDR=0:
  - Sequence: write AA, read expecting AA, write 55, read expecting 55.
  - done=1 at cycle 4.
REQ-036 In DONE, toggle en for 10 cycles: done stays 1, and we, re and addr stay 0.
REQ-037 With CHECKERBOARD_DESC_READ_EN defined and MAX_ADDR=3:
  - Cycles 8-11: re=1, addr 3,2,1,0, expected 55,AA,55,AA.
  - done=1 at cycle 24.

Source files
------------

// File: rtl/checkerboard_patgen.sv
// Checkerboard SRAM test-pattern generator: write/read sweeps of the background pattern and its inverse.
// Defining CHECKERBOARD_DESC_READ_EN adds a descending read sweep after each ascending read sweep.
module checkerboard_patgen #(
    parameter int MAX_ADDR   = 255,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int ADDR_WIDTH = (MAX_ADDR < 1) ? 1 : $clog2(MAX_ADDR + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [MASK_WIDTH-1:0] wmask,
    output logic                  we,
    output logic                  re,
    output logic [DATA_WIDTH-1:0] expected
);

    // Phases are numbered in execution order, so advancing is a plain increment.
`ifdef CHECKERBOARD_DESC_READ_EN
    localparam logic [2:0] W_CB   = 3'd0;
    localparam logic [2:0] R_CB   = 3'd1;
    localparam logic [2:0] RD_CB  = 3'd2;
    localparam logic [2:0] W_ICB  = 3'd3;
    localparam logic [2:0] R_ICB  = 3'd4;
    localparam logic [2:0] RD_ICB = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
`else
    localparam logic [2:0] W_CB   = 3'd0;
    localparam logic [2:0] R_CB   = 3'd1;
    localparam logic [2:0] W_ICB  = 3'd2;
    localparam logic [2:0] R_ICB  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_ADDR);

    logic [2:0]            phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  is_write;
    logic                  is_read;
    logic                  invert;
    logic [DATA_WIDTH-1:0] pat;
`ifdef CHECKERBOARD_DESC_READ_EN
    logic                  descending;
    logic                  next_desc;
`endif

    // Bit i of the background is i[0] ^ a[0]: 0xAA.. on even words, 0x55.. on odd.
    function automatic logic [DATA_WIDTH-1:0] bg_pat(input logic a0);
        logic [DATA_WIDTH-1:0] p;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p[i] = (i % 2 == 1) ^ a0;
        end
        return p;
    endfunction

    always_comb begin
        is_write = 1'b0;
        is_read  = 1'b0;
        invert   = 1'b0;
        case (phase_q)
            W_CB:   is_write = 1'b1;
            R_CB:   is_read  = 1'b1;
            W_ICB:  begin is_write = 1'b1; invert = 1'b1; end
            R_ICB:  begin is_read  = 1'b1; invert = 1'b1; end
`ifdef CHECKERBOARD_DESC_READ_EN
            RD_CB:  is_read = 1'b1;
            RD_ICB: begin is_read = 1'b1; invert = 1'b1; end
`endif
            default: ;
        endcase
    end

`ifdef CHECKERBOARD_DESC_READ_EN
    assign descending = (phase_q == RD_CB) || (phase_q == RD_ICB);
    assign next_desc  = (phase_q == R_CB)  || (phase_q == R_ICB);
`endif

    always_comb begin
        phase_d = phase_q;
        addr_d  = addr_q;
        if (en && (phase_q != DONE)) begin
`ifdef CHECKERBOARD_DESC_READ_EN
            if (descending) begin
                if (addr_q == '0) begin
                    phase_d = phase_q + 3'd1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q - ADDR_WIDTH'(1);
                end
            end else
`endif
            if (addr_q == LAST_ADDR) begin
                phase_d = phase_q + 3'd1;
                addr_d  = '0;
`ifdef CHECKERBOARD_DESC_READ_EN
                // A descending sweep starts from the top of the range.
                if (next_desc) addr_d = LAST_ADDR;
`endif
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= W_CB;
            addr_q  <= '0;
        end else begin
            phase_q <= phase_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        pat      = bg_pat(addr_q[0]) ^ {DATA_WIDTH{invert}};
        done     = (phase_q == DONE);
        addr     = done ? '0 : addr_q;
        we       = is_write & en;
        re       = is_read & en;
        data     = is_write ? pat : '0;
        wmask    = is_write ? {MASK_WIDTH{1'b1}} : '0;
        expected = is_read ? pat : '0;
    end

endmodule

// File: tb/tb_checkerboard_patgen.sv
// Scoreboard bench for checkerboard_patgen: a step-count reference model predicts every cycle's outputs.
module tb_checkerboard_patgen;

    typedef struct packed {
        logic       done;
        logic       we;
        logic       re;
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] wmask;
        logic [7:0] expected;
    } obs_t;

`ifdef CHECKERBOARD_DESC_READ_EN
    localparam int NPH = 6;
`else
    localparam int NPH = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, en0, done0, we0, re0;
    logic [1:0] addr0;
    logic [7:0] data0, exp0;
    logic [3:0] wmask0;

    logic       rst1, en1, done1, we1, re1;
    logic [0:0] addr1;
    logic [7:0] data1, exp1;
    logic [3:0] wmask1;

    checkerboard_patgen #(.MAX_ADDR(3), .DATA_WIDTH(8), .MASK_WIDTH(4)) dut0 (
        .clk(clk), .rst(rst0), .en(en0), .done(done0), .addr(addr0), .data(data0),
        .wmask(wmask0), .we(we0), .re(re0), .expected(exp0)
    );

    checkerboard_patgen #(.MAX_ADDR(0), .DATA_WIDTH(8), .MASK_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .done(done1), .addr(addr1), .data(data1),
        .wmask(wmask1), .we(we1), .re(re1), .expected(exp1)
    );

    obs_t q0[$];
    obs_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: k enabled steps since reset; phase = k / n, position within it = k % n.
    function automatic obs_t model(input int n, input int k, input bit en);
        obs_t r;
        int   ph, off, a;
        bit   wr, inv, desc;
        logic [7:0] pat;
        r = '0;
        if (k >= NPH * n) begin
            r.done = 1'b1;
            return r;
        end
        ph  = k / n;
        off = k % n;
`ifdef CHECKERBOARD_DESC_READ_EN
        wr   = (ph == 0) || (ph == 3);
        inv  = (ph >= 3);
        desc = (ph == 2) || (ph == 5);
`else
        wr   = (ph == 0) || (ph == 2);
        inv  = (ph >= 2);
        desc = 1'b0;
`endif
        a   = desc ? (n - 1 - off) : off;
        pat = (a % 2 == 0) ? 8'hAA : 8'h55;
        if (inv) pat = ~pat;
        r.addr = 8'(a);
        if (wr) begin
            r.we    = en;
            r.data  = pat;
            r.wmask = 4'hF;
        end else begin
            r.re       = en;
            r.expected = pat;
        end
        return r;
    endfunction

    task automatic compare(input string name, input obs_t got, input obs_t req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s @%0t: actual done=%0b we=%0b re=%0b addr=%0h data=%0h wmask=%0h exp=%0h | required done=%0b we=%0b re=%0b addr=%0h data=%0h wmask=%0h exp=%0h",
                     name, $time, got.done, got.we, got.re, got.addr, got.data, got.wmask, got.expected,
                     req.done, req.we, req.re, req.addr, req.data, req.wmask, req.expected);
        end
    endtask

    // Monitor: the DUTs present an operation every cycle; check it mid-cycle.
    always @(negedge clk) begin
        obs_t g;
        if (q0.size() > 0) begin
            g = '{done: done0, we: we0, re: re0, addr: 8'(addr0), data: data0,
                  wmask: wmask0, expected: exp0};
            compare("max3", g, q0.pop_front());
        end
        if (q1.size() > 0) begin
            g = '{done: done1, we: we1, re: re1, addr: 8'(addr1), data: data1,
                  wmask: wmask1, expected: exp1};
            compare("max0", g, q1.pop_front());
        end
    end

    initial begin
        int k0, k1;
        bit e0, r0, e1, r1;
        rst0 = 1'b1; en0 = 1'b0;
        rst1 = 1'b1; en1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        k0 = 0;
        k1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c < 20) begin
                e0 = 1'b1; r0 = 1'b0;
            end else if (c < 30) begin
                e0 = c[0]; r0 = 1'b0;
            end else if (c == 30 || c == 60) begin
                e0 = 1'b1; r0 = 1'b1;
            end else if (c < 100) begin
                e0 = !(c >= 36 && c <= 38); r0 = 1'b0;
            end else begin
                e0 = ($urandom_range(0, 3) != 0);
                r0 = ($urandom_range(0, 49) == 0);
            end
            if (c < 10) begin
                e1 = 1'b1; r1 = 1'b0;
            end else begin
                e1 = ($urandom_range(0, 2) != 0);
                r1 = ($urandom_range(0, 11) == 0);
            end
            en0 = e0; rst0 = r0;
            en1 = e1; rst1 = r1;
            q0.push_back(model(4, k0, e0));
            q1.push_back(model(1, k1, e1));
            k0 = r0 ? 0 : ((e0 && k0 < NPH * 4) ? k0 + 1 : k0);
            k1 = r1 ? 0 : ((e1 && k1 < NPH * 1) ? k1 + 1 : k1);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: actual pending=%0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
